mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001: Parameter DATA_W, default 32, operand and result width; the only supported value is 32.
REQ-002: Parameter STEPS, default 16, radix-4 iteration count, fixed at DATA_W/2.
REQ-003: clock  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005: ctrl_MULT  input  1  start pulse; operands are sampled in the same cycle.
REQ-006: data_operandA  input  32  multiplicand, two's complement.
REQ-007: data_operandB  input  32  multiplier, two's complement.
REQ-008: data_result  output  32  low 32 bits of the signed product.
REQ-009: data_exception  output  1  signed overflow flag; valid when data_resultRDY=1.
REQ-010: data_resultRDY  output  1  one-cycle done pulse.
REQ-011: busy  output  1  high while an operation is in flight.

Function
REQ-012: The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013: IDLE->RUN on ctrl_MULT=1; load acc[33:0]=0, mlier[31:0]=data_operandB, qm1=0, mcand=data_operandA, step counter=0.
REQ-014: Each RUN cycle SHALL recode the triplet {mlier[1],mlier[0],qm1}: 000/111 adds 0; 001/010 adds +M; 011 adds +2M; 100 adds -2M; 101/110 adds -M.
REQ-015: M SHALL be mcand sign-extended to 34 bits; 2M is M shifted left by 1; negation is bitwise invert plus carry-in 1 into the 34-bit adder.
REQ-016: After the add, {acc,mlier,qm1} SHALL arithmetic-shift right by 2 (acc sign bit replicated) and the counter SHALL increment.
REQ-017: RUN->DONE when the counter reaches STEPS-1 at the end of that cycle, giving exactly 16 RUN cycles.
REQ-018: In DONE, data_resultRDY=1 for exactly one cycle; data_result=mlier; data_exception=1 iff product bits [63:32] (acc[31:0]) are not all equal to mlier[31]; then DONE->IDLE.
REQ-019: Latency: with ctrl_MULT sampled at edge N, data_resultRDY SHALL be high in the cycle following edge N+17.
REQ-020: data_result and data_exception SHALL hold their last DONE values in IDLE until the next completion.
REQ-021: busy=1 in RUN and DONE, 0 in IDLE.
REQ-022: ctrl_MULT=1 during RUN or DONE SHALL abort the current operation, reload operands per REQ-013, and stay in or enter RUN; the aborted operation produces no resultRDY pulse.
REQ-023: Both operands equal to 0x80000000 SHALL be computed correctly: product 2^62, result 0, exception=1.
REQ-024: The 34-bit accumulator width SHALL absorb the ±2M range without wrap; no intermediate overflow is permitted.

Reset
REQ-025: reset=1 SHALL force state IDLE, counter 0, and acc, mlier, qm1, mcand to 0.
REQ-026: Under reset, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-027: reset SHALL take priority over ctrl_MULT in the same cycle.
REQ-028: Reset asserted mid-RUN SHALL discard the operation with no resultRDY pulse.

Structure
REQ-029: The shared package/include SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), STEPS, and the accumulator width 34.
REQ-030: Booth recoding plus add-value generation (0/±M/±2M and carry-in) SHALL be one combinational sub-module, booth_radix4_recode.
REQ-031: The sequencer SHALL own the FSM, counter, 66-bit {acc,mlier,qm1} register, and the 34-bit adder.

Verification
REQ-032: 3 x 5 -> resultRDY at cycle 17 after the start; result=0x0000000F; exception=0.
REQ-033: -7 x 6 -> result=0xFFFFFFD6; exception=0.
REQ-034: 0x7FFFFFFF x 2 -> result=0xFFFFFFFE; exception=1; 0x80000000 x 0xFFFFFFFF -> result=0x80000000; exception=1.
REQ-035: Start 4 x 4, re-pulse ctrl_MULT with 9 x 9 at RUN cycle 8 -> a single resultRDY pulse 17 cycles after the second start; result=0x00000051.
REQ-036: reset at RUN cycle 5 -> no resultRDY pulse; all outputs 0; a next start of 2 x 3 yields 6.
REQ-037: Random signed pairs (≥1000) checked against a 64-bit reference model for result and exception.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg: shared FSM state encodings, iteration count and accumulator width
package mult_sequencer_pkg;
  localparam int MULT_DATA_W = 32;
  localparam int MULT_STEPS = MULT_DATA_W / 2;
  localparam int ACC_W = 34;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: multiplier bus; master drives ctrl_MULT/data_operandA/data_operandB, slave returns data_result/data_exception/data_resultRDY/busy
interface mult_sequencer_if;
  logic ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_sequencer_booth_radix4_recode.sv
// booth_radix4_recode: radix-4 Booth triplet trip + multiplicand mcand -> 34-bit addend (0/+-M/+-2M, negation as invert) and cin
module booth_radix4_recode #(
  parameter int DATA_W = 32,
  parameter int ACC_W = DATA_W + 2
) (
  input  logic [2:0]        trip,
  input  logic [DATA_W-1:0] mcand,
  output logic [ACC_W-1:0]  addend,
  output logic              cin
);
  logic [ACC_W-1:0] m;
  logic [ACC_W-1:0] mag;
  logic one;
  logic two;
  always_comb begin
    m = {{(ACC_W-DATA_W){mcand[DATA_W-1]}}, mcand};
    one = trip[1] ^ trip[0];
    two = (trip == 3'b011) || (trip == 3'b100);
    cin = trip[2] && !(trip[1] && trip[0]);
    mag = two ? (m << 1) : one ? m : '0;
    addend = cin ? ~mag : mag;
  end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-4 Booth sequential signed multiplier; clock/reset plus slave bus (start+operands in, result/exception/resultRDY/busy out)
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int DATA_W = MULT_DATA_W,
  parameter int STEPS = MULT_STEPS
) (
  input logic clock,
  input logic reset,
  mult_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(STEPS);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mlier_q, mlier_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic qm1_q, qm1_d;
  logic exc_q, exc_d;
  logic rdy_q, rdy_d;
  logic busy_q, busy_d;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic cin;
  booth_radix4_recode #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_recode (
    .trip({mlier_q[1:0], qm1_q}),
    .mcand(mcand_q),
    .addend(addend),
    .cin(cin)
  );
  assign sum = acc_q + addend + ACC_W'(cin);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mlier_d = mlier_q;
    qm1_d = qm1_q;
    mcand_d = mcand_q;
    result_d = result_q;
    exc_d = exc_q;
    rdy_d = 1'b0;
    if (bus.ctrl_MULT) begin
      state_d = RUN;
      cnt_d = '0;
      acc_d = '0;
      mlier_d = bus.data_operandB;
      qm1_d = 1'b0;
      mcand_d = bus.data_operandA;
    end else if (state_q == RUN) begin
      acc_d = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
      mlier_d = {sum[1:0], mlier_q[DATA_W-1:2]};
      qm1_d = mlier_q[1];
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_W'(STEPS - 1)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      rdy_d = 1'b1;
      result_d = mlier_q;
      exc_d = acc_q[DATA_W-1:0] != {DATA_W{mlier_q[DATA_W-1]}};
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mlier_q <= '0;
      qm1_q <= 1'b0;
      mcand_q <= '0;
      result_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mlier_q <= mlier_d;
      qm1_q <= qm1_d;
      mcand_q <= mcand_d;
      result_q <= result_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  end
  assign bus.data_result = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy = busy_q;
endmodule
